// File: rtl/sram_1rw_req_rsp_if.sv
// rtl/sram_1rw_req_rsp_if.sv - request/response handshake bundle for sram_1rw_req_rsp
interface sram_1rw_req_rsp_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 512
);
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [MASK_WIDTH-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_1rw_req_rsp.sv
// rtl/sram_1rw_req_rsp.sv - single-port SRAM with valid/ready request and buffered read response
// Optional zero-fill sweep after reset is enabled by defining SRAM_CLEAR_ON_RESET_EN.
module sram_1rw_req_rsp #(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_1rw_req_rsp_if.slave bus,
  output logic              busy
);
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            occ;
  logic                  accept;
  logic                  push;
  logic                  pop;

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MASK_WIDTH-1:0] mem_mask;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef SRAM_CLEAR_ON_RESET_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy       = 1'b1;
        clr_we     = rst_n;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  assign clr_addr = clr_addr_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // occ counts every read not yet handed to the consumer, so the buffer can never overflow
  assign occ           = count_q + {1'b0, inflight_q};
  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_rdata = buf_q[rd_ptr_q];
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.req_ready = !busy && ((occ < 2'd2) || pop);
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = inflight_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.req_addr;
    mem_mask  = bus.req_wmask;
    mem_wdata = bus.req_wdata;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_mask  = '1;
      mem_wdata = '0;
    end else if (accept && bus.req_we && rst_n) begin
      mem_we = 1'b1;
    end
  end

  // Array and read register carry no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (mem_mask[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (accept && !bus.req_we) rd_q <= mem[bus.req_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= accept & !bus.req_we;
      if (push) begin
        buf_q[wr_ptr_q] <= rd_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(push && count_q == 2'd2));
  end
endmodule
